alu_issue: RTL and testbench

- Front end that drives the combinational ALU: accepts one RISC-V RV32I OP/OP-IMM instruction over a valid/ready handshake.
- Decodes it and reads a local 32x32 register file.
- Drives the ALU operand/control inputs (ra, rb, op, en, alt flag) for one cycle, captures the ALU result, writes back rd and reports retirement.
- Sits between instruction fetch and the ALU, so it is the producer/consumer end of the ALU's operand interface.

---
 rtl/alu_issue.sv | 133 +++++++++++++
 tb/tb_alu_issue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I OP/OP-IMM issue stage driving a combinational ALU
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic            alu_en,
    output logic [2:0]      alu_op,
    output logic            alu_func3,
    output logic [XLEN-1:0] alu_ra,
    output logic [XLEN-1:0] alu_rb,
    input  logic [XLEN-1:0] alu_out,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_ERR} state_t;

    localparam logic [6:0]      OPC_OP  = 7'b0110011;
    localparam logic [6:0]      OPC_IMM = 7'b0010011;
    localparam logic [6:0]      F7_ALT  = 7'b0100000;
    localparam logic [XLEN-1:0] MSB     = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, next_state;
    logic [31:0]     ir;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rf [NREGS];
    logic            legal;

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic       is_op;

    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign is_op = (opc == OPC_OP);

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] a);
        return (a == 5'd0) ? '0 : rf[a];
    endfunction

    assign dbg_data = read_reg(dbg_addr);

    // Legality is judged on the offered word so ERR is chosen at accept time
    always_comb begin
        legal = 1'b0;
        case (instr[6:0])
            OPC_OP: legal = (instr[31:25] == 7'd0) ||
                            (instr[31:25] == F7_ALT &&
                             (instr[14:12] == 3'b000 || instr[14:12] == 3'b101));
            OPC_IMM: begin
                case (instr[14:12])
                    3'b001:  legal = (instr[31:25] == 7'd0);
                    3'b101:  legal = (instr[31:25] == 7'd0) || (instr[31:25] == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (instr_valid) next_state = legal ? S_EXEC : S_ERR;
            S_EXEC:  next_state = S_WB;
            S_WB:    next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ir     <= '0;
            result <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && instr_valid) ir <= instr;
            if (state == S_EXEC) result <= alu_out;
            if (state == S_WB && rd != 5'd0) rf[rd] <= result;
        end
    end

    always_comb begin
        instr_ready  = (state == S_IDLE);
        alu_en       = 1'b0;
        alu_op       = 3'd0;
        alu_func3    = 1'b0;
        alu_ra       = '0;
        alu_rb       = '0;
        retire_valid = 1'b0;
        retire_rd    = 5'd0;
        retire_data  = '0;
        illegal      = (state == S_ERR);
        if (state == S_EXEC) begin
            alu_en = 1'b1;
            alu_op = f3;
            alu_ra = read_reg(rs1);
            alu_rb = is_op ? read_reg(rs2) : {{(XLEN-12){ir[31]}}, ir[31:20]};
            if (f3 == 3'b001 || f3 == 3'b101)
                alu_rb = {{(XLEN-5){1'b0}}, (is_op ? alu_rb[4:0] : ir[24:20])};
            // addi must never subtract, so OP-IMM only honours bit 30 for shifts
            if ((is_op && (f3 == 3'b000 || f3 == 3'b101)) || (!is_op && f3 == 3'b101))
                alu_func3 = ir[30];
            // Bias both operands so the ALU's signed compare gives the unsigned order
            if (f3 == 3'b011) begin
                alu_ra = alu_ra ^ MSB;
                alu_rb = alu_rb ^ MSB;
            end
        end
        if (state == S_WB) begin
            retire_valid = 1'b1;
            retire_rd    = rd;
            retire_data  = result;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural ALU
module tb_alu_issue;

    localparam logic [31:0] JUNK = 32'h00700393;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        alu_en;
    logic [2:0]  alu_op;
    logic        alu_func3;
    logic [31:0] alu_ra, alu_rb, alu_out;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int ill_pending = 0;
    logic [67:0] exec_q[$];
    logic [36:0] ret_q[$];

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_en(alu_en), .alu_op(alu_op),
        .alu_func3(alu_func3), .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_out(alu_out),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_data(retire_data),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic alt,
                                              input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'd0, $signed(a) < $signed(b)};
            3'b011:  return {31'd0, $signed(a) < $signed(b)};
            3'b100:  return a ^ b;
            3'b101:  return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_out = alu_model(alu_op, alu_func3, alu_ra, alu_rb);

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (alu_en) begin
                if (exec_q.size() == 0) chk("exec_unexpected", 68'd1, 68'd0);
                else chk("exec_ops", {alu_op, alu_func3, alu_ra, alu_rb}, exec_q.pop_front());
            end
            if (retire_valid) begin
                if (ret_q.size() == 0) chk("retire_unexpected", 68'd1, 68'd0);
                else chk("retire", {31'd0, retire_rd, retire_data}, {31'd0, ret_q.pop_front()});
            end
            if (illegal) begin
                if (ill_pending == 0) chk("illegal_unexpected", 68'd1, 68'd0);
                else ill_pending--;
            end
        end
    end

    task automatic issue(input logic [31:0] w, input bit is_legal);
        int n = 0;
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 68'd0, 68'd1);
        @(posedge clk);
        #1 instr = JUNK;
        @(negedge clk);
        chk("ready_busy1", {67'd0, instr_ready}, 68'd0);
        if (is_legal) chk("lat_exec", {67'd0, alu_en}, 68'd1);
        else          chk("lat_illegal", {67'd0, illegal}, 68'd1);
        if (is_legal) begin
            @(negedge clk);
            chk("ready_busy2", {67'd0, instr_ready}, 68'd0);
            chk("lat_retire", {67'd0, retire_valid}, 68'd1);
        end
        instr_valid = 1'b0;
    endtask

    task automatic run_legal(input logic [31:0] w, input logic [2:0] op, input logic alt,
                             input logic [31:0] ra, input logic [31:0] rb,
                             input logic [4:0] rd, input logic [31:0] data);
        exec_q.push_back({op, alt, ra, rb});
        ret_q.push_back({rd, data});
        issue(w, 1'b1);
    endtask

    task automatic run_illegal(input logic [31:0] w);
        ill_pending++;
        issue(w, 1'b0);
    endtask

    task automatic chk_reg(input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        dbg_addr = a;
        #1 chk($sformatf("dbg_x%0d", a), {36'd0, dbg_data}, {36'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 32'd0;
        dbg_addr = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {62'd0, instr_ready, alu_en, retire_valid, illegal, alu_func3, 1'b0},
            {62'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk_reg(5'd1, 32'd0);

        run_legal(32'hFFB00093, 3'd0, 1'b0, 32'h0, 32'hFFFFFFFB, 5'd1, 32'hFFFFFFFB);
        chk_reg(5'd1, 32'hFFFFFFFB);
        run_legal(32'h00100113, 3'd0, 1'b0, 32'h0, 32'h1, 5'd2, 32'h1);
        run_legal(32'h401102B3, 3'd0, 1'b1, 32'h1, 32'hFFFFFFFB, 5'd5, 32'h6);
        run_legal(32'h0020B1B3, 3'd3, 1'b0, 32'h7FFFFFFB, 32'h80000001, 5'd3, 32'h0);
        chk_reg(5'd3, 32'h0);
        run_legal(32'h0020A1B3, 3'd2, 1'b0, 32'hFFFFFFFB, 32'h1, 5'd3, 32'h1);
        run_legal(32'h4040D213, 3'd5, 1'b1, 32'hFFFFFFFB, 32'h4, 5'd4, 32'hFFFFFFFF);

        run_illegal(32'h0000006F);
        run_illegal(32'h02208033);
        run_legal(32'h00700013, 3'd0, 1'b0, 32'h0, 32'h7, 5'd0, 32'h7);

        chk_reg(5'd0, 32'd0);
        chk_reg(5'd2, 32'h1);
        chk_reg(5'd3, 32'h1);
        chk_reg(5'd4, 32'hFFFFFFFF);
        chk_reg(5'd5, 32'h6);
        chk_reg(5'd7, 32'h0);

        // Abandon addi x6 by resetting while it is in EXEC
        exec_q.push_back({3'd0, 1'b0, 32'h0, 32'h9});
        @(negedge clk);
        instr = 32'h00900313;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_exec_entered", {67'd0, alu_en}, 68'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_quiet", {65'd0, retire_valid, alu_en, illegal}, 68'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {67'd0, instr_ready}, 68'd1);
        chk_reg(5'd6, 32'd0);
        chk_reg(5'd1, 32'd0);

        chk("exec_q_drained", {36'd0, 32'(exec_q.size())}, 68'd0);
        chk("ret_q_drained", {36'd0, 32'(ret_q.size())}, 68'd0);
        chk("illegal_seen", {36'd0, 32'(ill_pending)}, 68'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
